// File: rtl/reset_sequencer.sv
// Staged reset sequencer: synchronised lock/master-reset inputs, lock filter,
// ordered domain release and re-sequencing. Optional SW request path: RST_SEQ_SW_RESET_EN.
module reset_sequencer #(
  parameter int NUM_DOMAINS = 2,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 8,
  parameter int RELEASE_GAP = 16,
  parameter int HOLD_CYCLES = 32
) (
  input  logic                   clk,
  input  logic                   areset_n,
  input  logic                   pll_locked_i,
  input  logic                   master_areset_i,
  input  logic                   sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0] domain_rst_n_o,
  output logic                   busy_o,
  output logic                   done_o
);

  // state     | meaning
  // WAIT_LOCK | all domains held, filtering ok for LOCK_FILTER cycles
  // RELEASE   | releasing domains in index order, RELEASE_GAP apart
  // RUN       | all domains released
  // HOLD      | all domains re-asserted for HOLD_CYCLES
  typedef enum logic [1:0] {WAIT_LOCK, RELEASE, RUN, HOLD} state_t;

  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int GW = $clog2(RELEASE_GAP + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILTER);
  localparam logic [GW-1:0] GAP_LOAD = GW'(RELEASE_GAP - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE = NUM_DOMAINS'(1);

  logic [1:0]             rst_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] mrst_sync;
  logic                   ok;

  state_t                 state_q, state_nxt;
  logic [FW-1:0]          filt_q, filt_nxt;
  logic [GW-1:0]          gap_q, gap_nxt;
  logic [HW-1:0]          hold_q, hold_nxt;
  logic [NUM_DOMAINS-1:0] dom_q, dom_nxt;
  logic                   busy_q, busy_nxt;
  logic                   done_q, done_nxt;

`ifndef RST_SEQ_SW_RESET_EN
  logic sw_rst_unused;
  assign sw_rst_unused = sw_rst_req_i;
`endif

  // Reset assertion is immediate; release is delayed two cycles before the FSM may advance.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      lock_sync <= '0;
      mrst_sync <= '1;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked_i};
      mrst_sync <= {mrst_sync[SYNC_STAGES-2:0], master_areset_i};
    end
  end

  assign ok = lock_sync[SYNC_STAGES-1] & ~mrst_sync[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state_q;
    filt_nxt  = filt_q;
    gap_nxt   = gap_q;
    hold_nxt  = hold_q;
    dom_nxt   = dom_q;
    busy_nxt  = 1'b1;
    done_nxt  = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        dom_nxt = '0;
        if (!ok) begin
          filt_nxt = '0;
        end else if (filt_q == FILT_MAX) begin
          state_nxt = RELEASE;
          gap_nxt   = GAP_LOAD;
          dom_nxt   = DOM_ONE;
        end else begin
          filt_nxt = filt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!ok) begin
          state_nxt = HOLD;
          hold_nxt  = HOLD_LOAD;
          filt_nxt  = '0;
          dom_nxt   = '0;
        end else if (dom_q[NUM_DOMAINS-1]) begin
          state_nxt = RUN;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else if (gap_q == '0) begin
          gap_nxt = GAP_LOAD;
          dom_nxt = (dom_q << 1) | DOM_ONE;
        end else begin
          gap_nxt = gap_q - 1'b1;
        end
      end
      RUN: begin
`ifdef RST_SEQ_SW_RESET_EN
        if (!ok || sw_rst_req_i) begin
`else
        if (!ok) begin
`endif
          state_nxt = HOLD;
          hold_nxt  = HOLD_LOAD;
          filt_nxt  = '0;
          dom_nxt   = '0;
        end else begin
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
        end
      end
      HOLD: begin
        dom_nxt = '0;
        if (hold_q == '0) begin
          state_nxt = WAIT_LOCK;
          filt_nxt  = '0;
        end else begin
          hold_nxt = hold_q - 1'b1;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= WAIT_LOCK;
      filt_q  <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      dom_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (!rst_sync[1]) begin
      state_q <= WAIT_LOCK;
      filt_q  <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      dom_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      filt_q  <= filt_nxt;
      gap_q   <= gap_nxt;
      hold_q  <= hold_nxt;
      dom_q   <= dom_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  assign domain_rst_n_o = dom_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a timeline model predicts output changes,
// a negedge monitor pops and compares them.
module tb_reset_sequencer;

  localparam int N    = 2;
  localparam int SYNC = 2;
  localparam int LF   = 8;
  localparam int GAP  = 16;
  localparam int HOLD = 32;
  localparam int W    = N + 2;
  localparam int REL_RUN = (N - 1) * GAP + 1;
`ifdef RST_SEQ_SW_RESET_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif
  localparam logic [W-1:0] RST_VAL = {{N{1'b0}}, 1'b1, 1'b0};

  logic         clk = 1'b0;
  logic         areset_n;
  logic         pll_locked_i;
  logic         master_areset_i;
  logic         sw_rst_req_i;
  logic [N-1:0] domain_rst_n_o;
  logic         busy_o;
  logic         done_o;

  reset_sequencer #(
    .NUM_DOMAINS(N), .SYNC_STAGES(SYNC), .LOCK_FILTER(LF),
    .RELEASE_GAP(GAP), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .areset_n(areset_n), .pll_locked_i(pll_locked_i),
    .master_areset_i(master_areset_i), .sw_rst_req_i(sw_rst_req_i),
    .domain_rst_n_o(domain_rst_n_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { int cyc; logic [W-1:0] val; } ev_t;
  ev_t q[$];
  logic [W-1:0] exp_cur = RST_VAL;
  logic [W-1:0] exp_before_last = RST_VAL;

  // Timeline model: rel_t counts cycles since domain 0 was released (-1 = not released).
  int cyc = 0;
  int en_cnt, filt, rel_t, hold_left;
  bit okh[$];

  function automatic void exp_set(input int c, input logic [W-1:0] v);
    if (v == exp_cur) return;
    if (q.size() > 0 && q[$].cyc == c) begin
      q[$].val = v;
      if (v == exp_before_last) void'(q.pop_back());
    end else begin
      exp_before_last = exp_cur;
      q.push_back('{c, v});
    end
    exp_cur = v;
  endfunction

  function automatic logic [W-1:0] model_out();
    logic [N-1:0] d;
    logic dn;
    for (int k = 0; k < N; k++) d[k] = (rel_t >= 0) && (rel_t >= k * GAP);
    dn = (rel_t >= REL_RUN);
    return {d, ~dn, dn};
  endfunction

  function automatic void model_reset();
    en_cnt = 0; filt = 0; rel_t = -1; hold_left = 0;
    okh.delete();
    for (int i = 0; i < SYNC; i++) okh.push_back(1'b0);
  endfunction

  function automatic void model_step();
    bit okf;
    okf = okh.pop_front();
    okh.push_back(pll_locked_i & ~master_areset_i);
    if (en_cnt < 2) begin
      en_cnt++;
    end else if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) filt = 0;
    end else if (rel_t >= 0) begin
      if (!okf || (SW_EN && sw_rst_req_i && rel_t >= REL_RUN)) begin
        hold_left = HOLD;
        rel_t = -1;
      end else if (rel_t < REL_RUN) begin
        rel_t++;
      end
    end else begin
      if (!okf) filt = 0;
      else if (filt == LF) rel_t = 0;
      else filt++;
    end
  endfunction

  always @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      model_reset();
      exp_set(cyc, model_out());
    end else begin
      cyc++;
      model_step();
      exp_set(cyc, model_out());
    end
  end

  bit           mon_on = 1'b0;
  logic [W-1:0] mon_prev;
  logic [W-1:0] mon_cur;
  ev_t          mon_ev;

  always @(negedge clk) begin
    if (mon_on) begin
      mon_cur = {domain_rst_n_o, busy_o, done_o};
      if (mon_cur !== mon_prev) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change cyc=%0d got=%b was=%b required no change", cyc, mon_cur, mon_prev);
        end else begin
          mon_ev = q.pop_front();
          if (mon_ev.cyc != cyc || mon_ev.val !== mon_cur) begin
            miscompares++;
            $display("FAIL output_event got cyc=%0d val=%b required cyc=%0d val=%b",
                     cyc, mon_cur, mon_ev.cyc, mon_ev.val);
          end
        end
        mon_prev = mon_cur;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_dom0(input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      seen = domain_rst_n_o[0];
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL wait_dom0_timeout got dom0=%b required 1 within %0d cycles", domain_rst_n_o[0], maxc);
    end
    tick();
  endtask

  task automatic wait_done(input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      seen = done_o;
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL wait_done_timeout got done=%b required 1 within %0d cycles", done_o, maxc);
    end
    tick();
  endtask

  initial begin
    areset_n = 1'b1; pll_locked_i = 1'b1; master_areset_i = 1'b0; sw_rst_req_i = 1'b0;
    #1 areset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (domain_rst_n_o !== '0) begin
      miscompares++;
      $display("FAIL reset_domains got=%b required=%b", domain_rst_n_o, {N{1'b0}});
    end
    vectors++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags got busy=%b done=%b required busy=1 done=0", busy_o, done_o);
    end
    mon_prev = {domain_rst_n_o, busy_o, done_o};
    mon_on = 1'b1;

    // power-up
    tick(5);
    areset_n = 1'b1;
    tick(60);

    // lock filter: one-cycle drop every 5 cycles, then steady
    for (int i = 0; i < 20; i++) begin
      pll_locked_i = 1'b0; tick();
      pll_locked_i = 1'b1; tick(4);
    end
    tick(70);

    // loss of lock in RUN
    wait_done(200);
    pll_locked_i = 1'b0; tick();
    pll_locked_i = 1'b1; tick(90);

    // master reset mid-RELEASE
    wait_dom0(200);
    tick(5);
    master_areset_i = 1'b1; tick(3);
    master_areset_i = 1'b0; tick(90);

    // software request in RUN, then in RELEASE
    wait_done(200);
    sw_rst_req_i = 1'b1; tick();
    sw_rst_req_i = 1'b0; tick(90);
    wait_dom0(200);
    tick(3);
    sw_rst_req_i = 1'b1; tick();
    sw_rst_req_i = 1'b0; tick(40);

    // simultaneous loss of lock and software request
    wait_done(200);
    tick(3);
    pll_locked_i = 1'b0; tick(2);
    sw_rst_req_i = 1'b1; tick();
    sw_rst_req_i = 1'b0; pll_locked_i = 1'b1; tick(90);

    // async reset mid-RELEASE
    wait_dom0(200);
    tick(4);
    areset_n = 1'b0; tick(2);
    areset_n = 1'b1; tick(60);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int drop_pct;
      drop_pct = (i < 1500) ? 4 : 1;
      pll_locked_i    = ($urandom_range(0, 99) >= drop_pct);
      master_areset_i = ($urandom_range(0, 199) == 0);
      sw_rst_req_i    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 399) == 0) begin
        areset_n = 1'b0; tick(2);
        areset_n = 1'b1;
      end
      tick();
    end
    pll_locked_i = 1'b1; master_areset_i = 1'b0; sw_rst_req_i = 1'b0;
    tick(100);

    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_events got=%0d required=0", q.size());
    end
    vectors++;
    if ({domain_rst_n_o, busy_o, done_o} !== exp_cur) begin
      miscompares++;
      $display("FAIL final_state got=%b required=%b", {domain_rst_n_o, busy_o, done_o}, exp_cur);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
